cp0_redirect_ctrl: RTL and testbench

//   Consumer side of the CP0 event interface. Samples the CP0 stage's Exception, Interrupt and ERET

---
 rtl/cp0_redirect_ctrl.sv | 115 +++++++++++
 tb/tb_cp0_redirect_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_redirect_ctrl.sv
// CP0 event consumer: flushes the pipeline, then redirects IF to the
// exception vector or EPC and masks further events until the drain ends.
module cp0_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Exception,
  input  logic             Interrupt,
  input  logic             ERET,
  input  logic [31:0]      CP0_EPC,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count,
  output logic [CNT_W-1:0] eret_count
);

  localparam int unsigned DW =
    (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    DRAIN
  } state_e;

  state_e           state_q;
  logic [DW-1:0]    drain_q;
  logic             flush_q;
  logic             valid_q;
  logic [31:0]      pc_q;
  logic             busy_q;
  logic [CNT_W-1:0] exc_cnt_q;
  logic [CNT_W-1:0] eret_cnt_q;

  logic exc_ev;
  logic any_ev;

  assign exc_ev = Exception | Interrupt;
  assign any_ev = exc_ev | ERET;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      flush_q    <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      exc_cnt_q  <= '0;
      eret_cnt_q <= '0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_ev) begin
            state_q <= REDIR;
            flush_q <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            if (exc_ev) begin
              pc_q <= EXC_VECTOR;
              if (exc_cnt_q != '1)
                exc_cnt_q <= exc_cnt_q + CNT_W'(1);
            end else begin
              pc_q <= CP0_EPC;
              if (eret_cnt_q != '1)
                eret_cnt_q <= eret_cnt_q + CNT_W'(1);
            end
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            valid_q <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DRAIN;
              drain_q <= DW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          // the edge that brings the counter to zero is the last masked edge
          if (drain_q <= DW'(1)) begin
            drain_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = valid_q;
  assign redirect_pc    = pc_q;
  assign busy           = busy_q;
  assign exc_count      = exc_cnt_q;
  assign eret_count     = eret_cnt_q;

endmodule

// File: tb/tb_cp0_redirect_ctrl.sv
// Directed bench for cp0_redirect_ctrl: default instance plus a
// 2-bit counter instance sharing the same stimulus.
module tb_cp0_redirect_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Exception;
  logic        Interrupt;
  logic        ERET;
  logic [31:0] CP0_EPC;
  logic        redirect_ready;

  logic        flush, valid, busy;
  logic [31:0] pc;
  logic [15:0] exc_count, eret_count;

  logic        s_flush, s_valid, s_busy;
  logic [31:0] s_pc;
  logic [1:0]  s_exc_count, s_eret_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_exc  = 0;
  int exp_eret = 0;

  always #5 clk = ~clk;

  cp0_redirect_ctrl dut (
    .clk(clk), .resetn(resetn),
    .Exception(Exception), .Interrupt(Interrupt),
    .ERET(ERET), .CP0_EPC(CP0_EPC),
    .redirect_ready(redirect_ready),
    .flush(flush), .redirect_valid(valid),
    .redirect_pc(pc), .busy(busy),
    .exc_count(exc_count), .eret_count(eret_count)
  );

  cp0_redirect_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn),
    .Exception(Exception), .Interrupt(Interrupt),
    .ERET(ERET), .CP0_EPC(CP0_EPC),
    .redirect_ready(redirect_ready),
    .flush(s_flush), .redirect_valid(s_valid),
    .redirect_pc(s_pc), .busy(s_busy),
    .exc_count(s_exc_count), .eret_count(s_eret_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    n_checks++;
    if ({flush, valid, busy} !== 3'b000 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs: flush=%b valid=%b busy=%b pc=%h required 0",
               flush, valid, busy, pc);
    end
    n_checks++;
    if (exc_count !== 16'd0 || eret_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: exc=%0d eret=%0d required 0",
               exc_count, eret_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({flush, valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: flush=%b valid=%b busy=%b required 000",
               flush, valid, busy);
    end
  endtask

  task automatic test_exception();
    redirect_ready = 1'b1;
    Exception = 1'b1;
    tick();
    Exception = 1'b0;
    exp_exc++;
    n_checks++;
    if ({flush, valid, busy} !== 3'b111 || pc !== VEC) begin
      n_fail++;
      $display("FAIL exc_issue: flush=%b valid=%b busy=%b pc=%h required 111 %h",
               flush, valid, busy, pc, VEC);
    end
    n_checks++;
    if (exc_count !== 16'(exp_exc)) begin
      n_fail++;
      $display("FAIL exc_count: got %0d required %0d", exc_count, exp_exc);
    end
    tick();
    n_checks++;
    if ({flush, valid, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL exc_hs: flush=%b valid=%b busy=%b required 001",
               flush, valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL exc_drain%0d: busy=%b required 1", i, busy);
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_done: busy=%b flush=%b required 0 0", busy, flush);
    end
  endtask

  task automatic test_eret_stall();
    redirect_ready = 1'b0;
    CP0_EPC = 32'h8000_1234;
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    CP0_EPC = 32'h0;
    exp_eret++;
    n_checks++;
    if ({flush, valid} !== 2'b11 || pc !== 32'h8000_1234) begin
      n_fail++;
      $display("FAIL eret_issue: flush=%b valid=%b pc=%h required 11 80001234",
               flush, valid, pc);
    end
    n_checks++;
    if (eret_count !== 16'(exp_eret) || exc_count !== 16'(exp_exc)) begin
      n_fail++;
      $display("FAIL eret_count: eret=%0d exc=%0d required %0d %0d",
               eret_count, exc_count, exp_eret, exp_exc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || pc !== 32'h8000_1234 || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL eret_hold%0d: valid=%b flush=%b pc=%h required 1 0 80001234",
                 i, valid, flush, pc);
      end
    end
    redirect_ready = 1'b1;
    tick();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL eret_hs: valid=%b busy=%b required 0 1", valid, busy);
    end
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL eret_done: busy=%b required 0", busy);
    end
  endtask

  task automatic test_priority();
    redirect_ready = 1'b1;
    CP0_EPC = 32'h1234_5678;
    Exception = 1'b1;
    ERET = 1'b1;
    tick();
    Exception = 1'b0;
    ERET = 1'b0;
    exp_exc++;
    n_checks++;
    if (pc !== VEC || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_pc: pc=%h valid=%b required %h 1", pc, valid, VEC);
    end
    n_checks++;
    if (exc_count !== 16'(exp_exc) || eret_count !== 16'(exp_eret)) begin
      n_fail++;
      $display("FAIL prio_cnt: exc=%0d eret=%0d required %0d %0d",
               exc_count, eret_count, exp_exc, exp_eret);
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1;
    int second = -1;
    redirect_ready = 1'b1;
    Interrupt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (flush === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    Interrupt = 1'b0;
    exp_exc += 2;
    n_checks++;
    if (pulses !== 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d required 2", pulses);
    end
    n_checks++;
    if (second - first !== 6) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d required 6", second - first);
    end
    n_checks++;
    if (exc_count !== 16'(exp_exc)) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d required %0d", exc_count, exp_exc);
    end
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    redirect_ready = 1'b0;
    Exception = 1'b1;
    tick();
    Exception = 1'b0;
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: valid=%b required 1", valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({flush, valid, busy} !== 3'b000 || pc !== 32'h0 ||
        exc_count !== 16'd0 || eret_count !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_async: flush=%b valid=%b busy=%b pc=%h exc=%0d eret=%0d required all 0",
               flush, valid, busy, pc, exc_count, eret_count);
    end
    exp_exc = 0;
    exp_eret = 0;
    @(negedge clk);
    resetn = 1'b1;
    redirect_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({flush, valid, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_post%0d: flush=%b valid=%b busy=%b required 000",
                 i, flush, valid, busy);
      end
    end
  endtask

  task automatic test_saturate();
    int req;
    redirect_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      Exception = 1'b1;
      tick();
      Exception = 1'b0;
      repeat (6) tick();
      req = (k > 3) ? 3 : k;
      n_checks++;
      if (s_exc_count !== 2'(req)) begin
        n_fail++;
        $display("FAIL sat_cnt%0d: got %0d required %0d", k, s_exc_count, req);
      end
    end
    n_checks++;
    if (exc_count !== 16'd5) begin
      n_fail++;
      $display("FAIL sat_wide: got %0d required 5", exc_count);
    end
  endtask

  initial begin
    resetn = 1'b0;
    Exception = 1'b0;
    Interrupt = 1'b0;
    ERET = 1'b0;
    CP0_EPC = 32'h0;
    redirect_ready = 1'b0;
    test_reset();
    test_exception();
    test_eret_stall();
    test_priority();
    test_back_to_back();
    test_reset_abort();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
